// File: rtl/add_sub_seq32_pkg.sv
// rtl/add_sub_seq32_pkg.sv - shared widths and FSM state type for the sequential 32-bit adder/subtractor
package add_sub_seq32_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/add_sub_seq32_cla_16.sv
// rtl/add_sub_seq32_cla_16.sv - combinational 16-bit carry-lookahead adder, four 4-bit lookahead groups
module cla_16
    import add_sub_seq32_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] s,
    output logic              cout
);

    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] c;
    logic [4:0]        gc;
    logic [3:0]        grp_g;
    logic [3:0]        grp_p;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gc    = '0;
        grp_g = '0;
        grp_p = '0;
        gc[0] = cin;
        // Each group resolves its internal carries directly from the group carry-in.
        for (int j = 0; j < 4; j++) begin
            c[4*j]     = gc[j];
            c[4*j + 1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j + 2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j + 3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                       | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
            grp_g[j]   = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                       | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j]   = &p[4*j +: 4];
            gc[j + 1]  = grp_g[j] | (grp_p[j] & gc[j]);
        end
        s    = p ^ c;
        cout = gc[4];
    end

endmodule

// File: rtl/add_sub_seq32.sv
// rtl/add_sub_seq32.sv - 32-bit add/subtract computed as two 16-bit halves through one shared CLA
module add_sub_seq32
    import add_sub_seq32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic [HALF_W-1:0] add_s;
    logic              add_co;

    cla_16 u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = opa_q[HALF_W-1:0];
        add_b   = opb_q[HALF_W-1:0];
        if (state_q == ST_HI) begin
            add_a = opa_q[DATA_W-1:HALF_W];
            add_b = opb_q[DATA_W-1:HALF_W];
        end
        unique case (state_q)
            ST_IDLE: begin
                // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b ^ {DATA_W{sub}};
                    carry_d = sub;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                sum_d[HALF_W-1:0] = add_s;
                carry_d           = add_co;
                state_d           = ST_HI;
            end
            ST_HI: begin
                sum_d[DATA_W-1:HALF_W] = add_s;
                cout_d                 = add_co;
                ovf_d   = (opa_q[DATA_W-1] == opb_q[DATA_W-1]) && (add_s[HALF_W-1] != opa_q[DATA_W-1]);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
